// File: rtl/bus_pkg.sv
// Shared types and constants for the bus copy master and its helpers.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RGAP,
    WR,
    WGAP
  } copy_state_t;

  localparam logic [3:0]  WSTRB_READ = 4'h0;
  localparam logic [3:0]  WSTRB_WORD = 4'hF;
  localparam logic [31:0] ADDR_STEP  = 32'd4;

endpackage

// File: rtl/bus_timeout.sv
// Bus request watchdog: counts stalled request cycles and flags expiry.
module bus_timeout #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Fires during the TIMEOUT-th stalled cycle so the FSM aborts on that edge.
  assign expired = inc && !clr && (cnt_q == 16'(TIMEOUT - 1));

endmodule

// File: rtl/bus_copy_master.sv
// Word-copy bus initiator for the PicoRV32 native memory interface.
module bus_copy_master
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_rdata
);

  copy_state_t      state_q, state_d;
  logic [31:0]      src_q, src_d, dst_q, dst_d, data_q, data_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             valid_q, valid_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             expired;

  bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (!valid_q),
    .inc     (valid_q && !mem_ready),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d = {src_addr[31:2], 2'b00};
          dst_d = {dst_addr[31:2], 2'b00};
          rem_d = len;
          err_d = 1'b0;
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RD;
            busy_d  = 1'b1;
            valid_d = 1'b1;
            addr_d  = {src_addr[31:2], 2'b00};
            wstrb_d = WSTRB_READ;
          end
        end
      end
      RD: begin
        if (expired) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (mem_ready) begin
          data_d  = mem_rdata;
          valid_d = 1'b0;
          state_d = RGAP;
        end
      end
      RGAP: begin
        state_d = WR;
        valid_d = 1'b1;
        addr_d  = dst_q;
        wdata_d = data_q;
        wstrb_d = WSTRB_WORD;
      end
      WR: begin
        if (expired) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (mem_ready) begin
          src_d   = src_q + ADDR_STEP;
          dst_d   = dst_q + ADDR_STEP;
          rem_d   = rem_q - LEN_W'(1);
          valid_d = 1'b0;
          // The final gap cycle is spent in IDLE so start is accepted alongside done.
          if (rem_q == LEN_W'(1)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = WGAP;
          end
        end
      end
      WGAP: begin
        state_d = RD;
        valid_d = 1'b1;
        addr_d  = src_q;
        wstrb_d = WSTRB_READ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_valid = valid_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_bus_copy_master.sv
// Scoreboard bench for bus_copy_master against a configurable memory responder.
module tb_bus_copy_master;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic        busy, done, err, mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  bus_copy_master #(.TIMEOUT(TO), .LEN_W(16)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // 0: one wait state, 1: never answers, 2: ready follows valid with one cycle lag
  int mode = 0;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) mem_ready <= 1'b0;
    else case (mode)
      0:       mem_ready <= mem_valid && !mem_ready;
      1:       mem_ready <= 1'b0;
      default: mem_ready <= mem_valid;
    endcase
  end

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h0010_0000: return 32'h0000_0093;
      32'h0010_0004: return 32'h0000_0193;
      32'h0010_0008: return 32'h0000_0213;
      default:       return {a[15:0], ~a[15:0]} ^ 32'h5A00_0000;
    endcase
  endfunction

  assign mem_rdata = mem_model(mem_addr);

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] wr_q[$];
  logic [31:0] rd_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one transfer and monitors it cycle by cycle; k counts cycles from the start edge.
  task automatic copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                      input int unsigned nexp, input bit inject,
                      output int done_cyc, output logic [63:0] vl, output int unsigned nrd,
                      output int unsigned nwr, output logic busy_any, output logic err_at_done);
    logic [31:0] sa, da;
    sa = {s[31:2], 2'b00};
    da = {d[31:2], 2'b00};
    for (int unsigned i = 0; i < nexp; i++) begin
      rd_q.push_back(sa + 32'(4 * i));
      wr_q.push_back(da + 32'(4 * i));
      wr_q.push_back(mem_model(sa + 32'(4 * i)));
    end
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; len = n;
    @(negedge clk);
    start = 1'b0;
    done_cyc = -1; vl = '0; nrd = 0; nwr = 0; busy_any = 1'b0; err_at_done = 1'b0;
    for (int k = 0; k < 400 && done_cyc < 0; k++) begin
      if (k > 0) @(negedge clk);
      if (inject && k == 4) begin
        start = 1'b1; src_addr = 32'h0000_1000; dst_addr = 32'h0000_2000; len = 16'd7;
      end else start = 1'b0;
      if (k < 64) vl[k] = mem_valid;
      busy_any = busy_any | busy;
      if (mem_valid && mem_ready) begin
        if (mem_wstrb == 4'hF) begin
          nwr++;
          if (wr_q.size() < 2) check("wr_extra", 32'd1, 32'd0);
          else begin
            check("wr_addr", mem_addr, wr_q.pop_front());
            check("wr_data", mem_wdata, wr_q.pop_front());
          end
        end else begin
          nrd++;
          if (rd_q.size() == 0) check("rd_extra", 32'd1, 32'd0);
          else check("rd_addr", mem_addr, rd_q.pop_front());
        end
      end
      if (done) begin
        done_cyc = k;
        err_at_done = err;
      end
    end
    start = 1'b0;
    if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
    check("sb_left", 32'(wr_q.size() + rd_q.size()), 32'd0);
    wr_q.delete();
    rd_q.delete();
    @(negedge clk);
    check("post_done", 32'(done), 32'd0);
    check("post_valid", 32'(mem_valid), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
  endtask

  int          dc;
  logic [63:0] vl;
  int unsigned nrd, nwr;
  logic        ba, ed;

  initial begin
    #1;
    check("rst_valid", 32'(mem_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Three-word copy with a one-wait responder
    mode = 0;
    copy(32'h0010_0000, 32'h0000_0040, 16'd3, 3, 1'b0, dc, vl, nrd, nwr, ba, ed);
    check("t1_done_cyc", 32'(dc), 32'd17);
    check("t1_err", 32'(ed), 32'd0);
    check("t1_nrd", nrd, 32'd3);
    check("t1_nwr", nwr, 32'd3);
    check("t1_valid_lo", {27'd0, vl[2], vl[5], vl[8], vl[11], vl[14]}, 32'd0);
    check("t1_valid_hi", {26'd0, vl[0], vl[1], vl[3], vl[4], vl[6], vl[16]}, 32'h3F);

    // Zero-length request
    copy(32'h0010_0000, 32'h0000_0040, 16'd0, 0, 1'b0, dc, vl, nrd, nwr, ba, ed);
    check("t2_done_cyc", 32'(dc), 32'd0);
    check("t2_busy", 32'(ba), 32'd0);
    check("t2_valid", vl[31:0], 32'd0);

    // Silent responder trips the timeout
    mode = 1;
    copy(32'h0010_0000, 32'h0000_0040, 16'd3, 0, 1'b0, dc, vl, nrd, nwr, ba, ed);
    check("t3_done_cyc", 32'(dc), 32'd8);
    check("t3_err", 32'(ed), 32'd1);
    check("t3_valid", vl[31:0], 32'h0000_00FF);
    check("t3_nwr", nwr, 32'd0);
    repeat (3) @(negedge clk);
    check("t3_err_held", 32'(err), 32'd1);

    // Ready lingering after valid falls must not count as a handshake
    mode = 2;
    copy(32'h0010_0000, 32'h0000_0200, 16'd4, 4, 1'b0, dc, vl, nrd, nwr, ba, ed);
    check("t4_done_cyc", 32'(dc), 32'd23);
    check("t4_err", 32'(ed), 32'd0);
    check("t4_nrd", nrd, 32'd4);
    check("t4_nwr", nwr, 32'd4);

    // Source address wraps past the top of the address space; low bits ignored
    mode = 0;
    copy(32'hFFFF_FFFF, 32'h0000_0083, 16'd2, 2, 1'b0, dc, vl, nrd, nwr, ba, ed);
    check("t5_done_cyc", 32'(dc), 32'd11);
    check("t5_nrd", nrd, 32'd2);

    // Start while busy is ignored
    copy(32'h0010_0000, 32'h0000_0300, 16'd3, 3, 1'b1, dc, vl, nrd, nwr, ba, ed);
    check("t6_done_cyc", 32'(dc), 32'd17);
    check("t6_nwr", nwr, 32'd3);

    // Reset asserted while a write is on the bus
    @(negedge clk);
    start = 1'b1; src_addr = 32'h0010_0000; dst_addr = 32'h0000_0400; len = 16'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("t7_in_wr", {30'd0, mem_valid, mem_wstrb == 4'hF}, 32'd3);
    rstn = 1'b0;
    #1;
    check("t7_rst_valid", 32'(mem_valid), 32'd0);
    check("t7_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    copy(32'h0010_0000, 32'h0000_0500, 16'd3, 3, 1'b0, dc, vl, nrd, nwr, ba, ed);
    check("t7_done_cyc", 32'(dc), 32'd17);
    check("t7_nwr", nwr, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
